sensor_scan_sequencer: RTL and testbench

SENSOR_SCAN_SEQUENCER -- requirements
Module: sensor_scan_sequencer

---
 rtl/sensor_scan_pkg.sv | 34 +++
 rtl/sensor_avg4.sv | 59 +++++
 rtl/sensor_scan_sequencer.sv | 160 ++++++++++++++++
 tb/tb_sensor_scan_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_scan_pkg.sv
// sensor_scan_pkg -- shared definitions for the greenhouse sensor scan sequencer.
//   NUM_CH      : number of ADC channels scanned per pass (9)
//   CH_*        : channel index of each sensor, in scan order
//   ch_t        : channel index type (matches the 4-bit adc_ch port)
//   sample_t    : raw / averaged 8-bit sensor value
//   state_t     : scan FSM states
package sensor_scan_pkg;

  localparam int NUM_CH = 9;
  localparam int CH_W   = 4;

  typedef logic [CH_W-1:0] ch_t;
  typedef logic [7:0]      sample_t;

  localparam ch_t CH_TEMPERATURE     = 4'd0;
  localparam ch_t CH_HUMIDITY        = 4'd1;
  localparam ch_t CH_SOIL_MOISTURE   = 4'd2;
  localparam ch_t CH_CO2_LEVEL       = 4'd3;
  localparam ch_t CH_LIGHT_INTENSITY = 4'd4;
  localparam ch_t CH_PRESSURE        = 4'd5;
  localparam ch_t CH_PH_LEVEL        = 4'd6;
  localparam ch_t CH_PEST_LEVEL      = 4'd7;
  localparam ch_t CH_LEAF_COLOR      = 4'd8;
  localparam ch_t LAST_CH            = CH_LEAF_COLOR;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    STORE,
    NEXT
  } state_t;

endpackage

// File: rtl/sensor_avg4.sv
// sensor_avg4 -- per-channel running mean of the last four accepted samples.
//   clk, rst : clock and asynchronous active-low reset (clears all history)
//   wr_en    : accept `sample` into the history of channel `ch`
//   ch       : channel whose history is read and (on wr_en) updated
//   sample   : incoming sample
//   avg      : mean of `sample` and the three previous samples of `ch`
//              (10-bit sum, truncated >>2); equals `sample` for a channel's
//              first accepted sample, which preloads its whole history.
// The incoming sample is always the newest of the four, so only the three
// older ones are stored; `avg` is combinational so the caller can register
// it in the same cycle it writes.
module sensor_avg4
  import sensor_scan_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    wr_en,
  input  ch_t     ch,
  input  sample_t sample,
  output sample_t avg
);

  sample_t             hist [NUM_CH][3];  // [0] oldest .. [2] newest
  logic [NUM_CH-1:0]   primed;
  logic [9:0]          sum;

  assign sum = primed[ch] ? (10'(hist[ch][0]) + 10'(hist[ch][1]) +
                             10'(hist[ch][2]) + 10'(sample))
                          : {sample, 2'b00};
  assign avg = 8'(sum >> 2);

  // NOTE: the history is a small register array, not a RAM, so it takes the
  // async reset like any other flop; a cleared history must never leak an
  // old mean after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < 3; k++) begin
          hist[c][k] <= '0;
        end
      end
      primed <= '0;
    end else if (wr_en) begin
      // NOTE: non-blocking assignments make the shift below read the
      // pre-edge history, so the entries move one slot without ordering games.
      if (!primed[ch]) begin
        hist[ch][0] <= sample;
        hist[ch][1] <= sample;
        hist[ch][2] <= sample;
        primed[ch]  <= 1'b1;
      end else begin
        hist[ch][0] <= hist[ch][1];
        hist[ch][1] <= hist[ch][2];
        hist[ch][2] <= sample;
      end
    end
  end

endmodule

// File: rtl/sensor_scan_sequencer.sv
// sensor_scan_sequencer -- periodically scans 9 ADC channels and holds the
// results as registered greenhouse sensor values.
// Parameters:
//   SCAN_DIV    : clk cycles between scan starts (>= 16)
//   ADC_TIMEOUT : max clk cycles spent waiting for adc_done on one channel
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   adc_start       : one-cycle conversion request for adc_ch
//   adc_ch          : channel under conversion (0..8)
//   adc_done        : conversion complete, qualifies adc_data (WAIT only)
//   adc_data        : raw conversion result
//   temperature .. leaf_color : registered sensor values, channels 0..8
//   sample_valid    : one-cycle pulse at the end of every scan
//   adc_fault       : some channel timed out in the last completed scan
// Build option: define SENSOR_AVG_EN to output the mean of the last four
// accepted samples per channel instead of the latest sample.
module sensor_scan_sequencer
  import sensor_scan_pkg::*;
#(
  parameter int SCAN_DIV    = 1000,
  parameter int ADC_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  output logic       adc_start,
  output logic [3:0] adc_ch,
  input  logic       adc_done,
  input  logic [7:0] adc_data,
  output logic [7:0] temperature,
  output logic [7:0] humidity,
  output logic [7:0] soil_moisture,
  output logic [7:0] co2_level,
  output logic [7:0] light_intensity,
  output logic [7:0] pressure,
  output logic [7:0] ph_level,
  output logic [7:0] pest_level,
  output logic [7:0] leaf_color,
  output logic       sample_valid,
  output logic       adc_fault
);

  localparam int               DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam int               TMO_W    = $clog2(ADC_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ADC_TIMEOUT - 1);

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic             scan_tick;
  logic [TMO_W-1:0] tmo_cnt;
  logic             scan_fault;   // sticky within the current scan
  sample_t          sample_q;     // captured in WAIT, written out in STORE
  sample_t          store_val;
  sample_t          sens [NUM_CH];

  // Free-running scan divider; it keeps counting during scans, so ticks
  // that land outside IDLE are simply lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign scan_tick = (div_cnt == DIV_LAST);

`ifdef SENSOR_AVG_EN
  sample_t avg_val;

  sensor_avg4 u_avg (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (state == STORE),
    .ch     (adc_ch),
    .sample (sample_q),
    .avg    (avg_val)
  );

  assign store_val = avg_val;
`else
  assign store_val = sample_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      adc_ch       <= CH_TEMPERATURE;
      adc_start    <= 1'b0;
      sample_valid <= 1'b0;
      adc_fault    <= 1'b0;
      scan_fault   <= 1'b0;
      tmo_cnt      <= '0;
      sample_q     <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        sens[c] <= '0;
      end
    end else begin
      // Both pulses are raised only on the transition that needs them.
      adc_start    <= 1'b0;
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (scan_tick) begin
            adc_ch     <= CH_TEMPERATURE;
            scan_fault <= 1'b0;
            adc_start  <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          // adc_done is tested first so it wins over a same-cycle timeout.
          if (adc_done) begin
            sample_q <= adc_data;
            state    <= STORE;
          end else if (tmo_cnt == TMO_LAST) begin
            scan_fault <= 1'b1;
            state      <= NEXT;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        STORE: begin
          sens[adc_ch] <= store_val;
          state        <= NEXT;
        end
        NEXT: begin
          if (adc_ch < LAST_CH) begin
            adc_ch    <= adc_ch + ch_t'(1);
            adc_start <= 1'b1;
            state     <= START;
          end else begin
            sample_valid <= 1'b1;
            adc_fault    <= scan_fault;
            adc_ch       <= CH_TEMPERATURE;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign temperature     = sens[CH_TEMPERATURE];
  assign humidity        = sens[CH_HUMIDITY];
  assign soil_moisture   = sens[CH_SOIL_MOISTURE];
  assign co2_level       = sens[CH_CO2_LEVEL];
  assign light_intensity = sens[CH_LIGHT_INTENSITY];
  assign pressure        = sens[CH_PRESSURE];
  assign ph_level        = sens[CH_PH_LEVEL];
  assign pest_level      = sens[CH_PEST_LEVEL];
  assign leaf_color      = sens[CH_LEAF_COLOR];

endmodule

// File: tb/tb_sensor_scan_sequencer.sv
// tb_sensor_scan_sequencer -- self-checking bench for sensor_scan_sequencer.
// A table of scan vectors configures a behavioural ADC; each scan's expected
// outputs, fault flag and tick-to-sample_valid latency are pushed to a
// scoreboard and compared when sample_valid fires. Hand-written sequences
// cover the idle spurious adc_done, reset in mid-scan and the averaging run.
module tb_sensor_scan_sequencer;
  import sensor_scan_pkg::*;

  localparam int SCAN_DIV    = 200;
  localparam int ADC_TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       adc_start;
  logic [3:0] adc_ch;
  logic       adc_done;
  logic [7:0] adc_data;
  logic [7:0] temperature, humidity, soil_moisture, co2_level, light_intensity;
  logic [7:0] pressure, ph_level, pest_level, leaf_color;
  logic       sample_valid;
  logic       adc_fault;

  always #5 clk = ~clk;

  sensor_scan_sequencer #(
    .SCAN_DIV    (SCAN_DIV),
    .ADC_TIMEOUT (ADC_TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .adc_start       (adc_start),
    .adc_ch          (adc_ch),
    .adc_done        (adc_done),
    .adc_data        (adc_data),
    .temperature     (temperature),
    .humidity        (humidity),
    .soil_moisture   (soil_moisture),
    .co2_level       (co2_level),
    .light_intensity (light_intensity),
    .pressure        (pressure),
    .ph_level        (ph_level),
    .pest_level      (pest_level),
    .leaf_color      (leaf_color),
    .sample_valid    (sample_valid),
    .adc_fault       (adc_fault)
  );

  logic [7:0] dut_out [NUM_CH];
  assign dut_out[0] = temperature;
  assign dut_out[1] = humidity;
  assign dut_out[2] = soil_moisture;
  assign dut_out[3] = co2_level;
  assign dut_out[4] = light_intensity;
  assign dut_out[5] = pressure;
  assign dut_out[6] = ph_level;
  assign dut_out[7] = pest_level;
  assign dut_out[8] = leaf_color;

  // Scan vector: channel c returns base + step*c after `lat` WAIT cycles,
  // except odd_ch which uses odd_lat (0 = never answers).
  typedef struct {
    int base;
    int step;
    int lat;
    int odd_ch;
    int odd_lat;
    bit exp_fault;
  } vec_t;

  typedef struct packed {
    logic [NUM_CH*8-1:0] vals;
    logic                fault;
    logic [31:0]         cycles;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t sb [$];
  vec_t cfg;
  bit   inj_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int base, int step, int lat, int odd_ch, int odd_lat, bit f);
    vec_t v;
    v.base = base; v.step = step; v.lat = lat;
    v.odd_ch = odd_ch; v.odd_lat = odd_lat; v.exp_fault = f;
    return v;
  endfunction

  function automatic int lat_of(vec_t v, int ch);
    return (ch == v.odd_ch) ? v.odd_lat : v.lat;
  endfunction

  // ---------------- reference model of the sensor outputs -----------------
  logic [7:0] mval [NUM_CH];
`ifdef SENSOR_AVG_EN
  int mhist [NUM_CH][4];
  bit mprimed [NUM_CH];
`endif

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      mval[c] = 8'd0;
`ifdef SENSOR_AVG_EN
      mprimed[c] = 1'b0;
      for (int k = 0; k < 4; k++) mhist[c][k] = 0;
`endif
    end
  endtask

  task automatic push_scan(input vec_t v);
    exp_t e;
    int   cyc;
    int   s;
    cyc = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (lat_of(v, c) == 0) begin
        cyc += ADC_TIMEOUT + 2;
      end else begin
        cyc += lat_of(v, c) + 3;
        s = (v.base + v.step * c) % 256;
`ifdef SENSOR_AVG_EN
        if (!mprimed[c]) begin
          for (int k = 0; k < 4; k++) mhist[c][k] = s;
          mprimed[c] = 1'b1;
        end else begin
          for (int k = 0; k < 3; k++) mhist[c][k] = mhist[c][k+1];
          mhist[c][3] = s;
        end
        mval[c] = 8'((mhist[c][0] + mhist[c][1] + mhist[c][2] + mhist[c][3]) / 4);
`else
        mval[c] = 8'(s);
`endif
      end
      e.vals[c*8 +: 8] = mval[c];
    end
    e.fault  = v.exp_fault;
    e.cycles = 32'(cyc);
    sb.push_back(e);
  endtask

  // ---------------- behavioural ADC --------------------------------------
  initial begin
    int         cnt;
    bit         pending;
    logic [7:0] val;
    int         l;
    pending = 1'b0;
    cnt     = 0;
    val     = 8'd0;
    forever begin
      @(negedge clk);
      adc_done = 1'b0;
      if (!rst) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          if (cnt == 0) begin
            adc_done = 1'b1;
            adc_data = val;
            pending  = 1'b0;
          end else begin
            cnt--;
          end
        end
        if (adc_start) begin
          l = lat_of(cfg, int'(adc_ch));
          if (l > 0) begin
            pending = 1'b1;
            cnt     = l - 1;
            val     = 8'((cfg.base + cfg.step * int'(adc_ch)) % 256);
          end
        end
        if (inj_done) begin
          adc_done = 1'b1;
          adc_data = 8'hAA;
          inj_done = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ---------------------------------
  int edges;
  int exp_ch;
  int starts;
  int scan_t0;
  int scans_done = 0;
  bit prev_start;

  always @(posedge clk or negedge rst) begin
    if (!rst) edges <= 0;
    else      edges <= edges + 1;
  end

  initial begin
    exp_t e;
    exp_ch = 0; starts = 0; scan_t0 = 0; prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_ch = 0; starts = 0; prev_start = 1'b0;
      end else begin
        if (adc_start) begin
          check("adc_start_one_cycle", 32'(prev_start), 0);
          check("adc_ch_seq", 32'(adc_ch), 32'(exp_ch));
          if (exp_ch == 0) begin
            check("tick_align", 32'(edges % SCAN_DIV), 0);
            scan_t0 = edges;
          end
          exp_ch++;
          starts++;
        end
        prev_start = adc_start;
        if (sample_valid) begin
          if (sb.size() == 0) begin
            check("extra_scan", 32'(sb.size()), 1);
          end else begin
            e = sb.pop_front();
            for (int c = 0; c < NUM_CH; c++)
              check($sformatf("scan%0d_ch%0d", scans_done, c), 32'(dut_out[c]), 32'(e.vals[c*8 +: 8]));
            check($sformatf("scan%0d_fault", scans_done), 32'(adc_fault), 32'(e.fault));
            check($sformatf("scan%0d_starts", scans_done), 32'(starts), 32'(NUM_CH));
            check($sformatf("scan%0d_latency", scans_done), 32'(edges - scan_t0), e.cycles);
          end
          exp_ch = 0;
          starts = 0;
          scans_done++;
        end
      end
    end
  end

  task automatic wait_scan();
    int target;
    int n;
    target = scans_done + 1;
    n = 0;
    while (scans_done < target && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    check("scan_in_time", 32'(scans_done >= target), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------------------------------
  initial begin
    vec_t       tbl [8];
    int         temps    [4];
    logic [7:0] exp_temp [4];
    int         snap;
    int         n;

    tbl[0] = mk( 25, 0,  5, -1,  0, 1'b0);  // all channels 25
    tbl[1] = mk( 40, 3,  5,  3,  0, 1'b1);  // ch3 silent -> timeout
    tbl[2] = mk( 90, 5,  7, -1,  0, 1'b0);  // clean scan clears fault
    tbl[3] = mk(150, 2,  5,  5, 64, 1'b0);  // ch5 done on timeout cycle
    tbl[4] = mk(200, 1, 60, -1,  0, 1'b0);  // scan longer than SCAN_DIV
    tbl[5] = mk(255, 0,  1, -1,  0, 1'b0);  // fastest ADC, max value
    tbl[6] = mk(  3, 1,  2,  8,  0, 1'b1);  // last channel times out
    tbl[7] = mk(  0, 0,  5, -1,  0, 1'b0);  // clean scan of zeros

    temps = '{20, 24, 28, 32};
`ifdef SENSOR_AVG_EN
    exp_temp = '{8'd20, 8'd21, 8'd23, 8'd26};
`else
    exp_temp = '{8'd20, 8'd24, 8'd28, 8'd32};
`endif

    rst      = 1'b0;
    adc_done = 1'b0;
    adc_data = 8'd0;
    inj_done = 1'b0;
    cfg      = tbl[0];
    model_reset();

    repeat (3) @(negedge clk);
    #1;
    check("rst_adc_start", 32'(adc_start), 0);
    check("rst_adc_ch", 32'(adc_ch), 0);
    check("rst_sample_valid", 32'(sample_valid), 0);
    check("rst_adc_fault", 32'(adc_fault), 0);
    for (int c = 0; c < NUM_CH; c++)
      check($sformatf("rst_out%0d", c), 32'(dut_out[c]), 0);

    for (int i = 0; i < 8; i++) begin
      cfg = tbl[i];
      push_scan(cfg);
      if (i == 0) begin
        @(negedge clk);
        rst = 1'b1;
      end
      wait_scan();
      if (i == 1) check("co2_held", 32'(co2_level), 25);
    end

    // Spurious adc_done while idle must change nothing.
    snap = scans_done;
    inj_done = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    for (int c = 0; c < NUM_CH; c++)
      check($sformatf("idle_hold%0d", c), 32'(dut_out[c]), 32'(mval[c]));
    check("idle_no_scan", 32'(scans_done), 32'(snap));
    check("idle_fault", 32'(adc_fault), 0);

    // Reset while waiting on channel 6.
    cfg = mk(77, 1, 5, -1, 0, 1'b0);
    push_scan(cfg);
    n = 0;
    while (!(adc_start && adc_ch == 4'd6) && n < 1000) begin
      @(negedge clk); #1;
      n++;
    end
    check("reached_ch6", 32'(adc_start && adc_ch == 4'd6), 1);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    sb.delete();
    model_reset();
    check("midrst_adc_start", 32'(adc_start), 0);
    check("midrst_adc_ch", 32'(adc_ch), 0);
    check("midrst_fault", 32'(adc_fault), 0);
    for (int c = 0; c < NUM_CH; c++)
      check($sformatf("midrst_out%0d", c), 32'(dut_out[c]), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Temperature sequence after reset (latest value or 4-sample mean).
    for (int k = 0; k < 4; k++) begin
      cfg = mk(temps[k], 1, 3, -1, 0, 1'b0);
      push_scan(cfg);
      wait_scan();
      check($sformatf("temp_seq%0d", k), 32'(temperature), 32'(exp_temp[k]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
